// File: rtl/tap_controller_if.sv
// Signal bundle between a JTAG TAP controller and its user.
// master: drives tms and observes the state, strobes and Run-Test/Idle counter.
// slave : the TAP controller itself; it samples tms and drives everything else.
// Ports carried:
//   tms        test mode select
//   state      current 4-bit TAP state encoding
//   tlr_n      low while in Test-Logic-Reset
//   clockir    IR clock enable (Capture-IR, Shift-IR)
//   shiftir    high in Shift-IR
//   updateir   high in Update-IR
//   clockdr    DR clock enable (Capture-DR, Shift-DR)
//   shiftdr    high in Shift-DR
//   updatedr   high in Update-DR
//   select     1 = IR path selected for the TDO mux
//   enable     TDO driver enable
//   rti_count  consecutive Run-Test/Idle cycles, saturating
interface tap_controller_if #(
  parameter int RTI_CNT_W = 4
) ();
  logic                 tms;
  logic [3:0]           state;
  logic                 tlr_n;
  logic                 clockir;
  logic                 shiftir;
  logic                 updateir;
  logic                 clockdr;
  logic                 shiftdr;
  logic                 updatedr;
  logic                 select;
  logic                 enable;
  logic [RTI_CNT_W-1:0] rti_count;

  modport master (
    output tms,
    input  state, tlr_n, clockir, shiftir, updateir,
    input  clockdr, shiftdr, updatedr, select, enable, rti_count
  );

  modport slave (
    input  tms,
    output state, tlr_n, clockir, shiftir, updateir,
    output clockdr, shiftdr, updatedr, select, enable, rti_count
  );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 16-state TAP controller with a saturating Run-Test/Idle dwell counter.
// Ports:
//   clock  TAP clock, all state updates on its rising edge
//   reset  synchronous active-low reset, forces Test-Logic-Reset and clears the counter
//   tap    slave side of tap_controller_if (tms in; state, strobes, rti_count out)
// Every output is a flop that holds the decode of the state the FSM is in, so the
// strobes are clean Moore signals with no combinational path from tms.
module tap_controller #(
  parameter int RTI_CNT_W = 4
) (
  input  logic           clock,
  input  logic           reset,
  tap_controller_if.slave tap
);

  localparam logic [3:0] TLR      = 4'hF;
  localparam logic [3:0] RTI      = 4'hC;
  localparam logic [3:0] SEL_DR   = 4'h7;
  localparam logic [3:0] CAP_DR   = 4'h6;
  localparam logic [3:0] SH_DR    = 4'h2;
  localparam logic [3:0] EX1_DR   = 4'h1;
  localparam logic [3:0] PAUSE_DR = 4'h3;
  localparam logic [3:0] EX2_DR   = 4'h0;
  localparam logic [3:0] UPD_DR   = 4'h5;
  localparam logic [3:0] SEL_IR   = 4'h4;
  localparam logic [3:0] CAP_IR   = 4'hE;
  localparam logic [3:0] SH_IR    = 4'hA;
  localparam logic [3:0] EX1_IR   = 4'h9;
  localparam logic [3:0] PAUSE_IR = 4'hB;
  localparam logic [3:0] EX2_IR   = 4'h8;
  localparam logic [3:0] UPD_IR   = 4'hD;

  localparam logic [RTI_CNT_W-1:0] CNT_MAX = {RTI_CNT_W{1'b1}};
  localparam logic [RTI_CNT_W-1:0] CNT_ONE = {{(RTI_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RTI_CNT_W-1:0] CNT_ZERO = {RTI_CNT_W{1'b0}};

  logic [3:0]           state_r;
  logic [3:0]           next_state_s;
  logic [8:0]           strobes_r;
  logic [RTI_CNT_W-1:0] rti_count_r;
  logic [RTI_CNT_W-1:0] next_count_s;

  // Output decode of one state, packed as
  // {tlr_n, clockir, shiftir, updateir, clockdr, shiftdr, updatedr, select, enable}.
  function automatic logic [8:0] decode_state(input logic [3:0] s);
    logic [8:0] d;
    d = 9'b1_0000_0000;
    case (s)
      TLR:      d = 9'b0_0000_0000;
      CAP_IR:   d = 9'b1_1000_0010;
      SH_IR:    d = 9'b1_1100_0011;
      UPD_IR:   d = 9'b1_0010_0010;
      SEL_IR,
      EX1_IR,
      PAUSE_IR,
      EX2_IR:   d = 9'b1_0000_0010;
      CAP_DR:   d = 9'b1_0001_0000;
      SH_DR:    d = 9'b1_0001_1001;
      UPD_DR:   d = 9'b1_0000_0100;
      default:  d = 9'b1_0000_0000;
    endcase
    return d;
  endfunction

  // Next-state logic of the TAP state diagram; any unexpected code falls back to TLR.
  always_comb begin
    next_state_s = TLR;
    case (state_r)
      TLR:      next_state_s = tap.tms ? TLR      : RTI;
      RTI:      next_state_s = tap.tms ? SEL_DR   : RTI;
      SEL_DR:   next_state_s = tap.tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state_s = tap.tms ? EX1_DR   : SH_DR;
      SH_DR:    next_state_s = tap.tms ? EX1_DR   : SH_DR;
      EX1_DR:   next_state_s = tap.tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state_s = tap.tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state_s = tap.tms ? UPD_DR   : SH_DR;
      UPD_DR:   next_state_s = tap.tms ? SEL_DR   : RTI;
      SEL_IR:   next_state_s = tap.tms ? TLR      : CAP_IR;
      CAP_IR:   next_state_s = tap.tms ? EX1_IR   : SH_IR;
      SH_IR:    next_state_s = tap.tms ? EX1_IR   : SH_IR;
      EX1_IR:   next_state_s = tap.tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state_s = tap.tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state_s = tap.tms ? UPD_IR   : SH_IR;
      UPD_IR:   next_state_s = tap.tms ? SEL_DR   : RTI;
      default:  next_state_s = TLR;
    endcase
  end

  // Dwell counter: counts edges spent staying in RTI, so it reads 0 on the first
  // RTI cycle, and reads 0 in every state other than RTI (including on the exit edge).
  always_comb begin
    next_count_s = CNT_ZERO;
    if (next_state_s == RTI && state_r == RTI) begin
      if (rti_count_r == CNT_MAX) begin
        next_count_s = CNT_MAX;
      end else begin
        next_count_s = rti_count_r + CNT_ONE;
      end
    end else begin
      next_count_s = CNT_ZERO;
    end
  end

  // State, strobe and counter registers; strobes are loaded with the decode of the
  // state being entered so they line up with the state register cycle for cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= TLR;
      strobes_r   <= decode_state(TLR);
      rti_count_r <= CNT_ZERO;
    end else begin
      state_r     <= next_state_s;
      strobes_r   <= decode_state(next_state_s);
      rti_count_r <= next_count_s;
    end
  end

  assign tap.state     = state_r;
  assign tap.tlr_n     = strobes_r[8];
  assign tap.clockir   = strobes_r[7];
  assign tap.shiftir   = strobes_r[6];
  assign tap.updateir  = strobes_r[5];
  assign tap.clockdr   = strobes_r[4];
  assign tap.shiftdr   = strobes_r[3];
  assign tap.updatedr  = strobes_r[2];
  assign tap.select    = strobes_r[1];
  assign tap.enable    = strobes_r[0];
  assign tap.rti_count = rti_count_r;

endmodule
